// File: rtl/cart_pkg.sv
// Shared types and timing defaults for the cartridge bus controller.
// Build macro CART_RST_PULSE_EN adds the CRST state and widens the phase counter to 8 bits.
package cart_pkg;

`ifdef CART_RST_PULSE_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        CRST   = 3'd4
    } cart_state_e;

    localparam int CNT_W = 8;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3
    } cart_state_e;

    localparam int CNT_W = 4;
`endif

    localparam int DEF_ADDR_W     = 16;
    localparam int DEF_DATA_W     = 8;
    localparam int DEF_SETUP_CYC  = 1;
    localparam int DEF_STROBE_CYC = 4;
    localparam int DEF_HOLD_CYC   = 1;
    localparam int DEF_RST_CYC    = 16;

endpackage

// File: rtl/cart_bus_ctrl.sv
// Cartridge bus controller: runs one SETUP/STROBE/HOLD access per accepted request.
// Build macro CART_RST_PULSE_EN holds the cartridge in reset for RST_CYC cycles after reset.
module cart_bus_ctrl
    import cart_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int SETUP_CYC  = DEF_SETUP_CYC,
    parameter int STROBE_CYC = DEF_STROBE_CYC,
    parameter int HOLD_CYC   = DEF_HOLD_CYC,
    parameter int RST_CYC    = DEF_RST_CYC
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_sram,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] cart_address,
    output logic [DATA_W-1:0] cart_data_out,
    output logic              cart_data_oe,
    input  logic [DATA_W-1:0] cart_data_in,
    output logic              cart_r_enable_l,
    output logic              cart_w_enable_l,
    output logic              cart_cs_sram_l,
    output logic              cart_reset_l
);

    localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] RST_LOAD    = CNT_W'(RST_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

`ifdef CART_RST_PULSE_EN
    localparam cart_state_e RESET_STATE = CRST;
`else
    localparam cart_state_e RESET_STATE = IDLE;
`endif

    cart_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              write_q, write_d;
    logic              sram_q, sram_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              req_ready_q, req_ready_d;
    logic              cs_l_q, cs_l_d;
    logic              oe_q, oe_d;
    logic              r_en_l_q, r_en_l_d;
    logic              w_en_l_q, w_en_l_d;
    logic              reset_l_q, reset_l_d;
    logic              busy;
    logic              cnt_done;

    // Next-state logic; pin values are decoded from the next state so every output is a flop.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        write_d     = write_q;
        sram_d      = sram_q;
        rdata_d     = rdata_q;
        rsp_valid_d = 1'b0;
        cnt_done    = (cnt_q == '0);

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    write_d = req_write;
                    sram_d  = req_sram;
                    state_d = SETUP;
                    cnt_d   = SETUP_LOAD;
                end
            end
            SETUP: begin
                if (cnt_done) begin
                    state_d = STROBE;
                    cnt_d   = STROBE_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            STROBE: begin
                if (cnt_done) begin
                    if (!write_q) begin
                        rdata_d = cart_data_in;
                    end
                    state_d = HOLD;
                    cnt_d   = HOLD_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            HOLD: begin
                if (cnt_done) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
`ifdef CART_RST_PULSE_EN
            CRST: begin
                if (cnt_done) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        busy        = (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);
        req_ready_d = (state_d == IDLE);
        cs_l_d      = ~(busy && sram_d);
        oe_d        = busy && write_d;
        r_en_l_d    = ~((state_d == STROBE) && !write_d);
        w_en_l_d    = ~((state_d == STROBE) && write_d);
`ifdef CART_RST_PULSE_EN
        reset_l_d   = (state_d != CRST);
`else
        reset_l_d   = 1'b1;
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= RESET_STATE;
            cnt_q       <= RST_LOAD;
            addr_q      <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
            sram_q      <= 1'b0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b0;
            cs_l_q      <= 1'b1;
            oe_q        <= 1'b0;
            r_en_l_q    <= 1'b1;
            w_en_l_q    <= 1'b1;
            reset_l_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            write_q     <= write_d;
            sram_q      <= sram_d;
            rdata_q     <= rdata_d;
            rsp_valid_q <= rsp_valid_d;
            req_ready_q <= req_ready_d;
            cs_l_q      <= cs_l_d;
            oe_q        <= oe_d;
            r_en_l_q    <= r_en_l_d;
            w_en_l_q    <= w_en_l_d;
            reset_l_q   <= reset_l_d;
        end
    end

    // The latched request fields double as the address and data pin registers.
    assign req_ready       = req_ready_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_rdata       = rdata_q;
    assign cart_address    = addr_q;
    assign cart_data_out   = wdata_q;
    assign cart_data_oe    = oe_q;
    assign cart_r_enable_l = r_en_l_q;
    assign cart_w_enable_l = w_en_l_q;
    assign cart_cs_sram_l  = cs_l_q;
    assign cart_reset_l    = reset_l_q;

endmodule

// File: tb/tb_cart_bus_ctrl.sv
// Testbench for cart_bus_ctrl: directed scenarios plus randomized accesses against a cycle-phase model.
// A second instance runs with non-default timing (SETUP 2, STROBE 1, HOLD 3).
module tb_cart_bus_ctrl;

    localparam int S   = 1;
    localparam int T   = 4;
    localparam int H   = 1;
    localparam int NT  = S + T + H;
    localparam int S2  = 2;
    localparam int T2  = 1;
    localparam int H2  = 3;
    localparam int NT2 = S2 + T2 + H2;
    localparam int RST_PULSE = 16;

    int vectors     = 0;
    int miscompares = 0;
    logic [7:0] exp_rdata;

    logic        clock;
    logic        reset;
    logic [7:0]  cart_data_in;

    logic        req_valid, req_ready, req_write, req_sram;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic [15:0] cart_address;
    logic [7:0]  cart_data_out;
    logic        cart_data_oe, cart_r_enable_l, cart_w_enable_l, cart_cs_sram_l, cart_reset_l;

    logic        t_req_valid, t_req_ready, t_req_write, t_req_sram;
    logic [15:0] t_req_addr;
    logic [7:0]  t_req_wdata;
    logic        t_rsp_valid;
    logic [7:0]  t_rsp_rdata;
    logic [15:0] t_cart_address;
    logic [7:0]  t_cart_data_out;
    logic        t_cart_data_oe, t_cart_r_enable_l, t_cart_w_enable_l, t_cart_cs_sram_l, t_cart_reset_l;

    cart_bus_ctrl dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_sram(req_sram),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .cart_address(cart_address), .cart_data_out(cart_data_out), .cart_data_oe(cart_data_oe),
        .cart_data_in(cart_data_in),
        .cart_r_enable_l(cart_r_enable_l), .cart_w_enable_l(cart_w_enable_l),
        .cart_cs_sram_l(cart_cs_sram_l), .cart_reset_l(cart_reset_l)
    );

    cart_bus_ctrl #(.SETUP_CYC(S2), .STROBE_CYC(T2), .HOLD_CYC(H2)) dut_t (
        .clock(clock), .reset(reset),
        .req_valid(t_req_valid), .req_ready(t_req_ready), .req_write(t_req_write), .req_sram(t_req_sram),
        .req_addr(t_req_addr), .req_wdata(t_req_wdata),
        .rsp_valid(t_rsp_valid), .rsp_rdata(t_rsp_rdata),
        .cart_address(t_cart_address), .cart_data_out(t_cart_data_out), .cart_data_oe(t_cart_data_oe),
        .cart_data_in(cart_data_in),
        .cart_r_enable_l(t_cart_r_enable_l), .cart_w_enable_l(t_cart_w_enable_l),
        .cart_cs_sram_l(t_cart_cs_sram_l), .cart_reset_l(t_cart_reset_l)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Releases reset and waits (bounded) until both instances are ready.
    task automatic release_reset();
        reset = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (req_ready && t_req_ready) return;
        end
        vectors++;
        miscompares++;
        $display("[TB] FAIL ready_after_reset got=%b exp=1", req_ready && t_req_ready);
    endtask

    task automatic test_reset();
        req_valid = 1'b0; req_write = 1'b0; req_sram = 1'b0; req_addr = '0; req_wdata = '0;
        t_req_valid = 1'b0; t_req_write = 1'b0; t_req_sram = 1'b0; t_req_addr = '0; t_req_wdata = '0;
        cart_data_in = 8'h00;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        vectors++;
        if ({req_ready, rsp_valid, cart_data_oe, cart_r_enable_l, cart_w_enable_l, cart_cs_sram_l, cart_reset_l} !== 7'b0001110) begin
            miscompares++;
            $display("[TB] FAIL reset_controls got=%b exp=%b",
                     {req_ready, rsp_valid, cart_data_oe, cart_r_enable_l, cart_w_enable_l, cart_cs_sram_l, cart_reset_l}, 7'b0001110);
        end
        vectors++;
        if ({cart_address, cart_data_out, rsp_rdata} !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_data got=%h exp=%h", {cart_address, cart_data_out, rsp_rdata}, 32'h0);
        end
        reset = 1'b0;
        @(negedge clock);
`ifdef CART_RST_PULSE_EN
        vectors++;
        if ({req_ready, cart_reset_l} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL first_edge_after_reset got=%b exp=00", {req_ready, cart_reset_l});
        end
        release_reset();
`else
        vectors++;
        if ({req_ready, cart_reset_l, t_req_ready} !== 3'b111) begin
            miscompares++;
            $display("[TB] FAIL first_edge_after_reset got=%b exp=111", {req_ready, cart_reset_l, t_req_ready});
        end
`endif
        exp_rdata = 8'h00;
    endtask

`ifdef CART_RST_PULSE_EN
    task automatic test_cart_reset();
        int bad;
        bad = 0;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        for (int i = 1; i <= RST_PULSE; i++) begin
            @(negedge clock);
            if (i < RST_PULSE && {req_ready, cart_reset_l} !== 2'b00) bad++;
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("[TB] FAIL crst_pulse_held got=%0d early-release cycles exp=0", bad);
        end
        vectors++;
        if ({req_ready, cart_reset_l} !== 2'b11) begin
            miscompares++;
            $display("[TB] FAIL crst_pulse_end got=%b exp=11", {req_ready, cart_reset_l});
        end
        exp_rdata = 8'h00;
    endtask
`endif

    task automatic test_read();
        int lat, r_low, w_low, oe_hi;
        lat = -1; r_low = 0; w_low = 0; oe_hi = 0;
        req_write = 1'b0; req_sram = 1'b0; req_addr = 16'h0150; cart_data_in = 8'hA5;
        req_valid = 1'b1;
        @(negedge clock);
        req_valid = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (!cart_r_enable_l) r_low++;
            if (!cart_w_enable_l) w_low++;
            if (cart_data_oe) oe_hi++;
            if (rsp_valid) begin lat = n; break; end
            @(negedge clock);
        end
        exp_rdata = 8'hA5;
        vectors++;
        if (lat !== NT) begin miscompares++; $display("[TB] FAIL read_latency got=%0d exp=%0d", lat, NT); end
        vectors++;
        if (r_low !== T) begin miscompares++; $display("[TB] FAIL read_strobe_len got=%0d exp=%0d", r_low, T); end
        vectors++;
        if (w_low + oe_hi !== 0) begin miscompares++; $display("[TB] FAIL read_no_write_pins got=%0d exp=0", w_low + oe_hi); end
        vectors++;
        if (rsp_rdata !== exp_rdata) begin miscompares++; $display("[TB] FAIL read_data got=%h exp=%h", rsp_rdata, exp_rdata); end
        vectors++;
        if (cart_address !== 16'h0150) begin miscompares++; $display("[TB] FAIL read_addr got=%h exp=0150", cart_address); end
    endtask

    task automatic test_write();
        int lat, cs_low, oe_hi, w_low, r_low, bad_data;
        lat = -1; cs_low = 0; oe_hi = 0; w_low = 0; r_low = 0; bad_data = 0;
        req_write = 1'b1; req_sram = 1'b1; req_addr = 16'hA000; req_wdata = 8'h3C;
        req_valid = 1'b1;
        @(negedge clock);
        req_valid = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (!cart_cs_sram_l) cs_low++;
            if (cart_data_oe) oe_hi++;
            if (cart_data_oe && cart_data_out !== 8'h3C) bad_data++;
            if (!cart_w_enable_l) w_low++;
            if (!cart_r_enable_l) r_low++;
            if (rsp_valid) begin lat = n; break; end
            @(negedge clock);
        end
        vectors++;
        if (lat !== NT) begin miscompares++; $display("[TB] FAIL write_latency got=%0d exp=%0d", lat, NT); end
        vectors++;
        if (cs_low !== NT || oe_hi !== NT) begin
            miscompares++;
            $display("[TB] FAIL write_cs_oe_len got=%0d/%0d exp=%0d/%0d", cs_low, oe_hi, NT, NT);
        end
        vectors++;
        if (w_low !== T) begin miscompares++; $display("[TB] FAIL write_strobe_len got=%0d exp=%0d", w_low, T); end
        vectors++;
        if (r_low + bad_data !== 0) begin miscompares++; $display("[TB] FAIL write_rd_strobe_or_data got=%0d exp=0", r_low + bad_data); end
        vectors++;
        if (rsp_rdata !== exp_rdata) begin miscompares++; $display("[TB] FAIL write_keeps_rdata got=%h exp=%h", rsp_rdata, exp_rdata); end
    endtask

    task automatic test_back_to_back();
        int lat1, lat2;
        lat1 = -1; lat2 = -1;
        cart_data_in = 8'h5A;
        req_write = 1'b0; req_sram = 1'b0; req_addr = 16'h0000;
        req_valid = 1'b1;
        @(negedge clock);
        for (int n = 0; n < 20; n++) begin
            if (rsp_valid) begin lat1 = n; break; end
            @(negedge clock);
        end
        exp_rdata = 8'h5A;
        vectors++;
        if (lat1 !== NT || req_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL b2b_first got lat=%0d ready=%b exp lat=%0d ready=1", lat1, req_ready, NT);
        end
        req_write = 1'b1; req_addr = 16'h2000; req_wdata = 8'hC3;
        @(negedge clock);
        req_valid = 1'b0;
        vectors++;
        if ({req_ready, cart_data_oe, cart_address} !== {2'b01, 16'h2000}) begin
            miscompares++;
            $display("[TB] FAIL b2b_second_accept got=%b/%b/%h exp=0/1/2000", req_ready, cart_data_oe, cart_address);
        end
        for (int n = 0; n < 20; n++) begin
            if (rsp_valid) begin lat2 = n; break; end
            @(negedge clock);
        end
        vectors++;
        if (lat2 !== NT) begin miscompares++; $display("[TB] FAIL b2b_second_latency got=%0d exp=%0d", lat2, NT); end
        vectors++;
        if (rsp_rdata !== exp_rdata) begin miscompares++; $display("[TB] FAIL b2b_rdata got=%h exp=%h", rsp_rdata, exp_rdata); end
    endtask

    // Model: after the accepting edge, sample n is SETUP for n<S, STROBE for S<=n<S+T,
    // HOLD for n<NT, and the response cycle at n==NT.
    task automatic test_random();
        logic        wr, sr, busy, strb;
        logic [15:0] a;
        logic [7:0]  wd, pending;
        logic [5:0]  got, expv;
        pending = 8'h00;
        for (int t = 0; t < 40; t++) begin
            repeat ($urandom_range(0, 2)) @(negedge clock);
            wr = 1'($urandom_range(0, 1));
            sr = 1'($urandom_range(0, 1));
            a  = 16'($urandom);
            wd = 8'($urandom);
            req_write = wr; req_sram = sr; req_addr = a; req_wdata = wd;
            req_valid = 1'b1;
            @(negedge clock);
            for (int n = 0; n <= NT; n++) begin
                busy = (n < NT);
                strb = (n >= S) && (n < S + T);
                if (!wr && n == S + T) exp_rdata = pending;
                got  = {req_ready, rsp_valid, cart_cs_sram_l, cart_data_oe, cart_r_enable_l, cart_w_enable_l};
                expv = {n == NT, n == NT, !(sr && busy), wr && busy, !(strb && !wr), !(strb && wr)};
                vectors++;
                if (got !== expv) begin
                    miscompares++;
                    $display("[TB] FAIL rand_ctrl txn=%0d n=%0d got=%b exp=%b", t, n, got, expv);
                end
                vectors++;
                if (cart_address !== a || (wr && busy && cart_data_out !== wd)) begin
                    miscompares++;
                    $display("[TB] FAIL rand_pins txn=%0d n=%0d got=%h/%h exp=%h/%h", t, n, cart_address, cart_data_out, a, wd);
                end
                vectors++;
                if (rsp_rdata !== exp_rdata) begin
                    miscompares++;
                    $display("[TB] FAIL rand_rdata txn=%0d n=%0d got=%h exp=%h", t, n, rsp_rdata, exp_rdata);
                end
                cart_data_in = 8'($urandom);
                if (n == S + T - 1) pending = cart_data_in;
                if (n < NT) begin
                    req_valid = 1'($urandom_range(0, 1));
                    req_addr  = 16'($urandom);
                    req_wdata = 8'($urandom);
                    req_write = 1'($urandom_range(0, 1));
                    req_sram  = 1'($urandom_range(0, 1));
                    @(negedge clock);
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        int found, seen;
        found = 0; seen = 0;
        req_write = 1'b1; req_sram = 1'b1; req_addr = 16'h1234; req_wdata = 8'h77;
        req_valid = 1'b1;
        @(negedge clock);
        req_valid = 1'b0;
        for (int n = 0; n < 10; n++) begin
            if (!cart_w_enable_l) begin found = 1; break; end
            @(negedge clock);
        end
        vectors++;
        if (found !== 1) begin miscompares++; $display("[TB] FAIL midrst_reach_strobe got=%0d exp=1", found); end
        reset = 1'b1;
        @(negedge clock);
        vectors++;
        if ({cart_r_enable_l, cart_w_enable_l, cart_data_oe, cart_cs_sram_l, rsp_valid} !== 5'b11010) begin
            miscompares++;
            $display("[TB] FAIL midrst_abort got=%b exp=11010",
                     {cart_r_enable_l, cart_w_enable_l, cart_data_oe, cart_cs_sram_l, rsp_valid});
        end
        reset = 1'b0;
        exp_rdata = 8'h00;
        for (int n = 0; n < 40; n++) begin
            @(negedge clock);
            if (rsp_valid) seen++;
        end
        vectors++;
        if (seen !== 0) begin miscompares++; $display("[TB] FAIL midrst_no_rsp got=%0d exp=0", seen); end
        vectors++;
        if (req_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL midrst_ready got=%b exp=1", req_ready); end
    endtask

    task automatic test_timing_params();
        int lat, r_low, w_low, oe_hi;
        lat = -1; r_low = 0;
        t_req_write = 1'b0; t_req_sram = 1'b0; t_req_addr = 16'h0042; cart_data_in = 8'h3E;
        t_req_valid = 1'b1;
        @(negedge clock);
        t_req_valid = 1'b0;
        for (int n = 0; n < 30; n++) begin
            if (!t_cart_r_enable_l) r_low++;
            if (t_rsp_valid) begin lat = n; break; end
            @(negedge clock);
        end
        vectors++;
        if (lat !== NT2) begin miscompares++; $display("[TB] FAIL tparam_read_latency got=%0d exp=%0d", lat, NT2); end
        vectors++;
        if (r_low !== T2) begin miscompares++; $display("[TB] FAIL tparam_read_strobe got=%0d exp=%0d", r_low, T2); end
        vectors++;
        if (t_rsp_rdata !== 8'h3E) begin miscompares++; $display("[TB] FAIL tparam_rdata got=%h exp=3e", t_rsp_rdata); end
        lat = -1; w_low = 0; oe_hi = 0;
        t_req_write = 1'b1; t_req_addr = 16'h0077; t_req_wdata = 8'h99;
        t_req_valid = 1'b1;
        @(negedge clock);
        t_req_valid = 1'b0;
        for (int n = 0; n < 30; n++) begin
            if (!t_cart_w_enable_l) w_low++;
            if (t_cart_data_oe) oe_hi++;
            if (t_rsp_valid) begin lat = n; break; end
            @(negedge clock);
        end
        vectors++;
        if (lat !== NT2 || w_low !== T2 || oe_hi !== NT2) begin
            miscompares++;
            $display("[TB] FAIL tparam_write got lat=%0d w=%0d oe=%0d exp lat=%0d w=%0d oe=%0d",
                     lat, w_low, oe_hi, NT2, T2, NT2);
        end
    endtask

    initial begin
        test_reset();
`ifdef CART_RST_PULSE_EN
        test_cart_reset();
`endif
        test_read();
        test_write();
        test_back_to_back();
        test_random();
        test_mid_reset();
        test_timing_params();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
